// File: rtl/lc3_mem_arbiter_pkg.sv
// Shared LC-3 types: control FSM state encoding plus the memory arbiter's states and owner tag.
// Arbiter states are plain constants so legacy code can compare against raw 2-bit values.
package lc3Pkg;

   typedef logic [5:0] ControlStates;

   typedef logic [1:0] ArbStates;
   localparam ArbStates ARB_IDLE  = 2'd0;
   localparam ArbStates ARB_ISSUE = 2'd1;
   localparam ArbStates ARB_WAIT  = 2'd2;
   localparam ArbStates ARB_DONE  = 2'd3;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } Owner;

endpackage

// File: rtl/lc3_mem_arbiter_rr_pick.sv
// Two-input round-robin picker; winner is combinational, last-grant register advances on upd.
// Last grant resets to DMA so the CPU takes the first tie.
module lc3_rr_pick
   import lc3Pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_cpu,
   input  logic req_dma,
   input  logic upd,
   output logic winner
);

   Owner last_q, last_d;
   Owner win;

   always_comb begin
      win = OWN_CPU;
      if (req_cpu && req_dma) begin
         win = (last_q == OWN_CPU) ? OWN_DMA : OWN_CPU;
      end else if (req_dma) begin
         win = OWN_DMA;
      end
      last_d = upd ? win : last_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= OWN_DMA;
      end else begin
         last_q <= last_d;
      end
   end

   assign winner = (win == OWN_DMA);

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Single-port memory shared between the CPU port and a DMA master, one access at a time.
// Ack lands MEM_LAT+1 cycles after the request is seen in IDLE; rdata is passed through in the ack cycle.
module lc3_mem_arbiter
   import lc3Pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);

   ArbStates          state_q, state_d;
   Owner              owner_q, owner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
   logic              grant;
   logic              pick_dma;
   logic              rd_done_cpu;
   logic              rd_done_dma;

   assign grant = (state_q == ARB_IDLE) && (cpu_req || dma_req);

   lc3_rr_pick u_pick (
      .clk     (clk),
      .rst     (rst),
      .req_cpu (cpu_req),
      .req_dma (dma_req),
      .upd     (grant),
      .winner  (pick_dma)
   );

   assign rd_done_cpu = (state_q == ARB_DONE) && (owner_q == OWN_CPU) && !mem_we_q;
   assign rd_done_dma = (state_q == ARB_DONE) && (owner_q == OWN_DMA) && !mem_we_q;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      case (state_q)
         ARB_IDLE: begin
            // The mem_* registers double as the latched request, so later input changes cannot leak in.
            if (grant) begin
               state_d     = ARB_ISSUE;
               owner_d     = pick_dma ? OWN_DMA : OWN_CPU;
               mem_we_d    = pick_dma ? dma_we    : cpu_we;
               mem_addr_d  = pick_dma ? dma_addr  : cpu_addr;
               mem_wdata_d = pick_dma ? dma_wdata : cpu_wdata;
            end
         end
         ARB_ISSUE: begin
            if (MEM_LAT > 1) begin
               state_d = ARB_WAIT;
               cnt_d   = CNT_W'(MEM_LAT - 1);
            end else begin
               state_d = ARB_DONE;
            end
         end
         ARB_WAIT: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = ARB_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ARB_DONE: begin
            state_d = ARB_IDLE;
            if (rd_done_cpu) cpu_rdata_d = mem_rdata;
            if (rd_done_dma) dma_rdata_d = mem_rdata;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         owner_q     <= OWN_CPU;
         cnt_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

   assign mem_en    = (state_q == ARB_ISSUE);
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q != ARB_IDLE);
   assign cpu_ack   = (state_q == ARB_DONE) && (owner_q == OWN_CPU);
   assign dma_ack   = (state_q == ARB_DONE) && (owner_q == OWN_DMA);
   assign cpu_rdata = rd_done_cpu ? mem_rdata : cpu_rdata_q;
   assign dma_rdata = rd_done_dma ? mem_rdata : dma_rdata_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench: instance A at MEM_LAT=1, instance B at MEM_LAT=3, each with its own memory model.
module tb_lc3_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic        rst_a, a_cpu_req, a_cpu_we, a_cpu_ack, a_dma_req, a_dma_we, a_dma_ack;
   logic        a_mem_en, a_mem_we, a_busy;
   logic [15:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata, a_dma_addr, a_dma_wdata, a_dma_rdata;
   logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

   logic        rst_b, b_cpu_req, b_cpu_we, b_cpu_ack, b_dma_req, b_dma_we, b_dma_ack;
   logic        b_mem_en, b_mem_we, b_busy;
   logic [15:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata, b_dma_addr, b_dma_wdata, b_dma_rdata;
   logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

   lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut_a (
      .clk(clk), .rst(rst_a),
      .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
      .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
      .dma_req(a_dma_req), .dma_we(a_dma_we), .dma_addr(a_dma_addr), .dma_wdata(a_dma_wdata),
      .dma_ack(a_dma_ack), .dma_rdata(a_dma_rdata),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_rdata(a_mem_rdata), .busy(a_busy)
   );

   lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) dut_b (
      .clk(clk), .rst(rst_b),
      .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
      .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
      .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
      .dma_ack(b_dma_ack), .dma_rdata(b_dma_rdata),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata), .busy(b_busy)
   );

   // Memory models: read sampled before the write at the same edge, data delayed MEM_LAT cycles.
   logic [15:0] mem_a [0:65535];
   logic [15:0] mem_b [0:65535];
   logic [15:0] pa1, pb1, pb2, pb3;
   int          en_cnt_a = 0;

   always @(posedge clk) begin
      if (a_mem_en) begin
         pa1 <= mem_a[a_mem_addr];
         en_cnt_a <= en_cnt_a + 1;
         if (a_mem_we) mem_a[a_mem_addr] = a_mem_wdata;
      end
      if (b_mem_en) begin
         pb1 <= mem_b[b_mem_addr];
         if (b_mem_we) mem_b[b_mem_addr] = b_mem_wdata;
      end
      pb2 <= pb1;
      pb3 <= pb2;
   end
   assign a_mem_rdata = pa1;
   assign b_mem_rdata = pb3;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int who[4];
      int cyc[4];
      int n, en0, ack_c, busy_n, en_n, acks;
      logic [15:0] rd;

      mem_a[16'h3000] = 16'h1234;
      mem_a[16'h5000] = 16'h5555;
      mem_b[16'h3000] = 16'hCAFE;
      rst_a = 1'b1; rst_b = 1'b1;
      a_cpu_req = 0; a_cpu_we = 0; a_cpu_addr = 0; a_cpu_wdata = 0;
      a_dma_req = 0; a_dma_we = 0; a_dma_addr = 0; a_dma_wdata = 0;
      b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
      b_dma_req = 0; b_dma_we = 0; b_dma_addr = 0; b_dma_wdata = 0;
      step(); step();
      chk("rst_cpu_ack", a_cpu_ack, 0);
      chk("rst_dma_ack", a_dma_ack, 0);
      chk("rst_mem_en", a_mem_en, 0);
      chk("rst_mem_we", a_mem_we, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_mem_addr", a_mem_addr, 0);
      chk("rst_mem_wdata", a_mem_wdata, 0);
      chk("rst_cpu_rdata", a_cpu_rdata, 0);
      chk("rst_dma_rdata", a_dma_rdata, 0);
      rst_a = 1'b0; rst_b = 1'b0;
      step();

      // CPU read 0x3000 at MEM_LAT=1
      a_cpu_addr = 16'h3000; a_cpu_req = 1;
      chk("rd_t0_mem_en", a_mem_en, 0);
      step();
      chk("rd_t1_mem_en", a_mem_en, 1);
      chk("rd_t1_mem_we", a_mem_we, 0);
      chk("rd_t1_mem_addr", a_mem_addr, 16'h3000);
      chk("rd_t1_busy", a_busy, 1);
      chk("rd_t1_cpu_ack", a_cpu_ack, 0);
      step();
      chk("rd_t2_cpu_ack", a_cpu_ack, 1);
      chk("rd_t2_cpu_rdata", a_cpu_rdata, 16'h1234);
      chk("rd_t2_dma_ack", a_dma_ack, 0);
      chk("rd_t2_mem_en", a_mem_en, 0);
      a_cpu_req = 0;
      step();
      chk("rd_t3_busy", a_busy, 0);
      chk("rd_t3_cpu_ack", a_cpu_ack, 0);
      chk("rd_t3_rdata_hold", a_cpu_rdata, 16'h1234);

      // DMA write 0x4000 <- 0xBEEF
      en0 = en_cnt_a;
      a_dma_addr = 16'h4000; a_dma_wdata = 16'hBEEF; a_dma_we = 1; a_dma_req = 1;
      step();
      chk("wr_mem_en", a_mem_en, 1);
      chk("wr_mem_we", a_mem_we, 1);
      chk("wr_mem_addr", a_mem_addr, 16'h4000);
      chk("wr_mem_wdata", a_mem_wdata, 16'hBEEF);
      step();
      chk("wr_dma_ack", a_dma_ack, 1);
      chk("wr_dma_rdata_unchanged", a_dma_rdata, 0);
      a_dma_req = 0; a_dma_we = 0;
      step();
      chk("wr_en_pulses", en_cnt_a - en0, 1);
      chk("wr_dma_rdata_after", a_dma_rdata, 0);

      // Both requests held: CPU reads 0x4000, DMA reads 0x3000
      a_cpu_addr = 16'h4000; a_dma_addr = 16'h3000;
      a_cpu_req = 1; a_dma_req = 1;
      n = 0;
      for (int c = 1; c <= 20 && n < 4; c++) begin
         step();
         if (a_cpu_ack && a_dma_ack) chk("tie_dual_ack", 1, 0);
         if (a_cpu_ack) begin
            who[n] = 0; cyc[n] = c; n++;
            if (n == 1) chk("cpu_read_after_dma_write", a_cpu_rdata, 16'hBEEF);
         end else if (a_dma_ack) begin
            who[n] = 1; cyc[n] = c; n++;
            if (n == 2) chk("tie_dma_rdata", a_dma_rdata, 16'h1234);
         end
      end
      a_cpu_req = 0; a_dma_req = 0;
      chk("tie_ack_count", n, 4);
      if (n > 0) chk("tie_first_ack_cycle", cyc[0], 2);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("tie_owner_%0d", i), who[i], i % 2);
         if (i > 0) chk($sformatf("tie_gap_%0d", i), cyc[i] - cyc[i-1], 3);
      end
      step();

      // Address changes after grant must not affect the access
      a_cpu_addr = 16'h3000; a_cpu_req = 1;
      step();
      chk("lat_mem_addr", a_mem_addr, 16'h3000);
      a_cpu_addr = 16'h5000;
      step();
      chk("lat_cpu_ack", a_cpu_ack, 1);
      chk("lat_cpu_rdata", a_cpu_rdata, 16'h1234);
      a_cpu_req = 0;
      step();

      // MEM_LAT=3 CPU read
      b_cpu_addr = 16'h3000; b_cpu_req = 1;
      ack_c = 0; busy_n = 0; en_n = 0; rd = 0;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (b_busy) busy_n++;
         if (b_mem_en) en_n++;
         if (b_cpu_ack && ack_c == 0) begin
            ack_c = c; rd = b_cpu_rdata; b_cpu_req = 0;
         end
      end
      chk("l3_ack_cycle", ack_c, 4);
      chk("l3_rdata", rd, 16'hCAFE);
      chk("l3_busy_cycles", busy_n, 4);
      chk("l3_en_pulses", en_n, 1);

      // Reset during WAIT
      b_cpu_req = 1;
      step();
      chk("rw_issue_en", b_mem_en, 1);
      step();
      chk("rw_wait_busy", b_busy, 1);
      rst_b = 1; b_cpu_req = 0;
      step();
      chk("rw_busy", b_busy, 0);
      chk("rw_cpu_ack", b_cpu_ack, 0);
      chk("rw_mem_en", b_mem_en, 0);
      chk("rw_mem_addr", b_mem_addr, 0);
      chk("rw_cpu_rdata", b_cpu_rdata, 0);
      rst_b = 0;
      acks = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (b_cpu_ack || b_dma_ack) acks++;
      end
      chk("rw_no_late_ack", acks, 0);

      // Tie after reset: CPU must win again
      b_dma_addr = 16'h3000; b_cpu_req = 1; b_dma_req = 1;
      ack_c = 0; n = -1;
      for (int c = 1; c <= 10 && ack_c == 0; c++) begin
         step();
         if (b_cpu_ack) begin ack_c = c; n = 0; end
         else if (b_dma_ack) begin ack_c = c; n = 1; end
      end
      b_cpu_req = 0; b_dma_req = 0;
      chk("rw_tie_winner", n, 0);
      chk("rw_tie_ack_cycle", ack_c, 4);
      step(); step(); step(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
